// File: rtl/regfile_param.sv
// Parametrised register file: two registered read ports with write-first bypass,
// post-reset clear sweep. Optional macro REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module regfile_param #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] r1_add,
  input  logic [ADDR_W-1:0] r2_add,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_add,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  r1_value,
  output logic [WIDTH-1:0]  r2_value,
  output logic              rd_valid,
  output logic              busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef enum logic {ST_SWEEP, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  r1_q, r1_d, r2_q, r2_d;
  logic              valid_q, valid_d;
  logic              wr_ok, zero1, zero2, fwd1, fwd2;

  // Sweep control: the edge that clears the last entry also leaves the sweep state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    zero1 = ZERO_EN && (r1_add == '0);
    zero2 = ZERO_EN && (r2_add == '0);
    wr_ok = write_enable && !(ZERO_EN && (write_add == '0));
    fwd1  = write_enable && (write_add == r1_add);
    fwd2  = write_enable && (write_add == r2_add);
  end

  // Read path: zero entry takes priority over bypass, bypass over the stored value.
  always_comb begin
    r1_d    = r1_q;
    r2_d    = r2_q;
    valid_d = 1'b0;
    if (state_q == ST_RUN && rd_en) begin
      valid_d = 1'b1;
      if (zero1)     r1_d = '0;
      else if (fwd1) r1_d = wr_data;
      else           r1_d = mem_q[r1_add];
      if (zero2)     r2_d = '0;
      else if (fwd2) r2_d = wr_data;
      else           r2_d = mem_q[r2_add];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q    <= '0;
      r2_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      valid_q <= valid_d;
    end
  end

  // Storage is left untouched by reset; the sweep does the clearing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_SWEEP) mem_q[cnt_q] <= '0;
      else if (wr_ok)          mem_q[write_add] <= wr_data;
    end
  end

  assign r1_value = r1_q;
  assign r2_value = r2_q;
  assign rd_valid = valid_q;
  assign busy     = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default build checked against a behavioural
// model under directed and random stimulus, plus a WIDTH=64/ADDR_W=3 instance.
module tb_regfile_param;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DUT A: default parameters
  logic        a_rst = 1'b1, a_rd = 1'b0, a_we = 1'b0;
  logic [4:0]  a_a1 = '0, a_a2 = '0, a_wa = '0;
  logic [31:0] a_wd = '0;
  logic [31:0] a_r1, a_r2;
  logic        a_v, a_busy;

  regfile_param u_a (
    .clk(clk), .reset(a_rst), .rd_en(a_rd), .r1_add(a_a1), .r2_add(a_a2),
    .write_enable(a_we), .write_add(a_wa), .wr_data(a_wd),
    .r1_value(a_r1), .r2_value(a_r2), .rd_valid(a_v), .busy(a_busy)
  );

  // DUT B: wide, shallow variant
  logic        b_rst = 1'b1, b_rd = 1'b0, b_we = 1'b0;
  logic [2:0]  b_a1 = '0, b_a2 = '0, b_wa = '0;
  logic [63:0] b_wd = '0;
  logic [63:0] b_r1, b_r2;
  logic        b_v, b_busy;

  regfile_param #(.WIDTH(64), .ADDR_W(3)) u_b (
    .clk(clk), .reset(b_rst), .rd_en(b_rd), .r1_add(b_a1), .r2_add(b_a2),
    .write_enable(b_we), .write_add(b_wa), .wr_data(b_wd),
    .r1_value(b_r1), .r2_value(b_r2), .rd_valid(b_v), .busy(b_busy)
  );

  // Reference model for DUT A
  logic [31:0] m_mem [32];
  logic [31:0] m_r1 = '0, m_r2 = '0;
  logic        m_v = 1'b0, m_busy = 1'b1;
  int          m_left = 32;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mval(input logic [4:0] a, input logic we,
                                       input logic [4:0] wa, input logic [31:0] wd);
    if (ZERO && a == 5'd0) return 32'd0;
    if (we && wa == a)     return wd;
    return m_mem[a];
  endfunction

  task automatic step(input logic rst, input logic rd, input logic [4:0] a1, input logic [4:0] a2,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    a_rst = rst; a_rd = rd; a_a1 = a1; a_a2 = a2; a_we = we; a_wa = wa; a_wd = wd;
    @(posedge clk); #1;
    if (rst) begin
      m_r1 = '0; m_r2 = '0; m_v = 1'b0; m_busy = 1'b1; m_left = 32;
    end else if (m_busy) begin
      m_v = 1'b0;
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else begin
      if (rd) begin
        m_r1 = mval(a1, we, wa, wd);
        m_r2 = mval(a2, we, wa, wd);
        m_v  = 1'b1;
      end else begin
        m_v = 1'b0;
      end
      if (we && !(ZERO && wa == 5'd0)) m_mem[wa] = wd;
    end
    chk("r1_value", 64'(a_r1), 64'(m_r1));
    chk("r2_value", 64'(a_r2), 64'(m_r2));
    chk("rd_valid", 64'(a_v), 64'(m_v));
    chk("busy", 64'(a_busy), 64'(m_busy));
  endtask

  task automatic rnd_step(input logic rst);
    step(rst, 1'($urandom_range(1)), 5'($urandom_range(31)), 5'($urandom_range(31)),
         1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
  endtask

  // Counts busy cycles starting from the sample just after the last reset edge.
  task automatic sweep_len(output int n);
    n = a_busy ? 1 : 0;
    while (a_busy && n < 64) begin
      rnd_step(1'b0);
      if (a_busy) n++;
    end
  endtask

  task automatic stepb;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    foreach (m_mem[i]) m_mem[i] = '0;

    // Reset held two cycles, then the initial sweep with ignored requests
    step(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 32'h1234);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    sweep_len(n);
    chk("sweep_len_initial", 64'(n), 64'd32);

    // Basic write then read
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF);
    step(1'b0, 1'b1, 5'd7, 5'd3, 1'b0, 5'd0, 32'h0);
    chk("basic_r1", 64'(a_r1), 64'hDEADBEEF);
    chk("basic_r2", 64'(a_r2), 64'h0);
    chk("basic_valid", 64'(a_v), 64'd1);
    step(1'b0, 1'b0, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0);
    chk("hold_r1", 64'(a_r1), 64'hDEADBEEF);
    chk("hold_valid", 64'(a_v), 64'd0);

    // Bypass on both ports
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h11);
    step(1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'h22);
    chk("bypass_r1", 64'(a_r1), 64'h22);
    chk("bypass_r2", 64'(a_r2), 64'h22);
    step(1'b0, 1'b1, 5'd9, 5'd7, 1'b0, 5'd0, 32'h0);
    chk("after_bypass_r1", 64'(a_r1), 64'h22);

    // Entry 0: same-cycle write/read, then a later read
    step(1'b0, 1'b1, 5'd0, 5'd7, 1'b1, 5'd0, 32'h55);
    chk("zero_bypass", 64'(a_r1), ZERO ? 64'h0 : 64'h55);
    step(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    chk("zero_later", 64'(a_r1), ZERO ? 64'h0 : 64'h55);

    // Random traffic with narrow address range for collisions and rare resets
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(99) == 0), 1'($urandom_range(1)),
           5'($urandom_range(7)), 5'($urandom_range(7)),
           1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
    end
    while (m_busy) rnd_step(1'b0);

    // Preload, reset 2 cycles, confirm sweep length and that everything reads 0
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'(i), $urandom | 32'h1);
    step(1'b0, 1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 32'h0);
    step(1'b1, 1'b1, 5'd5, 5'd6, 1'b1, 5'd5, 32'hAA);
    chk("reset_r1_zero", 64'(a_r1), 64'h0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    sweep_len(n);
    chk("sweep_len_preload", 64'(n), 64'd32);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);

    // Reset during the sweep restarts it
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h44);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 10; i++) rnd_step(1'b0);
    step(1'b1, 1'b1, 5'd4, 5'd4, 1'b1, 5'd4, 32'h99);
    chk("midsweep_reset_busy", 64'(a_busy), 64'd1);
    sweep_len(n);
    chk("sweep_len_restart", 64'(n), 64'd32);
    step(1'b0, 1'b1, 5'd4, 5'd4, 1'b0, 5'd0, 32'h0);
    chk("restart_cleared", 64'(a_r1), 64'h0);

    // Wide/shallow instance
    b_rst = 1'b1; stepb;
    chk("b_reset_busy", 64'(b_busy), 64'd1);
    b_rst = 1'b0;
    n = 1;
    while (b_busy && n < 20) begin
      stepb;
      if (b_busy) n++;
    end
    chk("b_sweep_len", 64'(n), 64'd8);
    b_we = 1'b1; b_wa = 3'd5; b_wd = 64'hFFFF0000FFFF0000; stepb;
    b_we = 1'b0; b_rd = 1'b1; b_a1 = 3'd5; b_a2 = 3'd4; stepb;
    chk("b_r1", b_r1, 64'hFFFF0000FFFF0000);
    chk("b_r2", b_r2, 64'h0);
    chk("b_valid", 64'(b_v), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
